// File: rtl/frame_capture_streamer.sv
// Single-frame capture buffer: stores one multi-channel frame on request, then streams every
// channel of every pixel as an OUT_BITS word over a valid/ready handshake.
module frame_capture_streamer #(
  parameter int unsigned WIDTH    = 320,
  parameter int unsigned HEIGHT   = 100,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned CH_BITS  = 10,
  parameter int unsigned OUT_BITS = 8,
  parameter int unsigned SEL_MSB  = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         arm,
  input  logic                         start_frame,
  input  logic                         pixel_valid,
  input  logic [CHANNELS*CH_BITS-1:0]  pixel_input,
  input  logic                         out_ready,
  output logic [OUT_BITS-1:0]          out_data,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         sync_error
);

  localparam int unsigned NPIX = WIDTH * HEIGHT;
  localparam int unsigned PW   = CHANNELS * CH_BITS;
  localparam int unsigned AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [AW-1:0] LastPix = AW'(NPIX - 1);
  localparam logic [CW-1:0] LastCh  = CW'(CHANNELS - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StStream} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic            init_q, init_d;
  logic            ld_q, ld_d;
  logic [PW-1:0]   pix_q, pix_d;
  logic            out_valid_q, out_valid_d;
  logic            frame_done_q, frame_done_d;
  logic            sync_error_q, sync_error_d;

  logic            wr_en;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic            xfer;
  logic [PW-1:0]   ram_rdata_q;
  logic [PW-1:0]   mem_q [NPIX];
  logic [CH_BITS-1:0] ch_word;

  // Frame store: never reset, synchronous read with one cycle of latency.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_cnt_q] <= pixel_input;
    end
    if (rd_en) begin
      ram_rdata_q <= mem_q[rd_addr];
    end
  end

  assign xfer = out_valid_q && out_ready;

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    ch_d         = ch_q;
    pix_d        = pix_q;
    out_valid_d  = out_valid_q;
    init_d       = 1'b0;
    ld_d         = 1'b0;
    frame_done_d = 1'b0;
    sync_error_d = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    rd_addr      = rd_cnt_q;

    // RAM data fetched last cycle lands in the pixel word register.
    if (ld_q) begin
      pix_d       = ram_rdata_q;
      out_valid_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (arm) begin
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (start_frame) begin
          state_d  = StCapture;
          wr_cnt_d = '0;
        end
      end
      StCapture: begin
        if (start_frame) begin
          wr_cnt_d     = '0;
          sync_error_d = 1'b1;
        end else if (pixel_valid) begin
          wr_en = 1'b1;
          if (wr_cnt_q == LastPix) begin
            state_d  = StStream;
            rd_cnt_d = '0;
            ch_d     = '0;
            init_d   = 1'b1;
          end else begin
            wr_cnt_d = wr_cnt_q + AW'(1);
          end
        end
      end
      StStream: begin
        if (init_q) begin
          rd_en   = 1'b1;
          rd_addr = '0;
        end
        if (xfer) begin
          if (ch_q == LastCh) begin
            ch_d        = '0;
            out_valid_d = 1'b0;
            if (rd_cnt_q == LastPix) begin
              state_d      = StIdle;
              frame_done_d = 1'b1;
            end else begin
              // Prefetch the next pixel during its predecessor's last transfer.
              rd_cnt_d = rd_cnt_q + AW'(1);
              rd_en    = 1'b1;
              rd_addr  = rd_cnt_q + AW'(1);
            end
          end else begin
            ch_d = ch_q + CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    ld_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      ch_q         <= '0;
      init_q       <= 1'b0;
      ld_q         <= 1'b0;
      pix_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      sync_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      ch_q         <= ch_d;
      init_q       <= init_d;
      ld_q         <= ld_d;
      pix_q        <= pix_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      sync_error_q <= sync_error_d;
    end
  end

  always_comb begin
    ch_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch_q == CW'(k)) begin
        ch_word = pix_q[k*CH_BITS +: CH_BITS];
      end
    end
  end

  always_comb begin
    if (SEL_MSB != 0) begin
      out_data = ch_word[CH_BITS-1 -: OUT_BITS];
    end else begin
      out_data = ch_word[OUT_BITS-1:0];
    end
  end

  assign out_valid  = out_valid_q;
  assign busy       = (state_q != StIdle);
  assign frame_done = frame_done_q;
  assign sync_error = sync_error_q;

endmodule

// File: tb/tb_frame_capture_streamer.sv
// Bench for frame_capture_streamer: an LSB-select and an MSB-select instance share stimulus;
// a negedge monitor pops expected words from per-instance queues.
module tb_frame_capture_streamer;

  localparam int NPIX = 8;
  localparam int CH   = 3;
  localparam int CB   = 10;
  localparam int PW   = CH * CB;
  localparam int NW   = NPIX * CH;

  logic          clk = 1'b0;
  logic          reset;
  logic          arm;
  logic          start_frame;
  logic          pixel_valid;
  logic [PW-1:0] pixel_input;
  logic          out_ready;
  logic [7:0]    out_data, out_data_m;
  logic          out_valid, out_valid_m;
  logic          busy, busy_m;
  logic          frame_done, frame_done_m;
  logic          sync_error, sync_error_m;

  int tests = 0;
  int fails = 0;
  int words_seen = 0;
  int fd_cnt = 0;
  int se_cnt = 0;

  logic [7:0]    exp_q[$];
  logic [7:0]    exp_m_q[$];
  logic [PW-1:0] frm [NPIX];

  logic          hold_pend = 1'b0;
  logic [7:0]    hold_data = '0;

  always #5 clk = ~clk;

  frame_capture_streamer #(
    .WIDTH(4), .HEIGHT(2), .CHANNELS(3), .CH_BITS(10), .OUT_BITS(8), .SEL_MSB(0)
  ) u_dut (
    .clk(clk), .reset(reset), .arm(arm), .start_frame(start_frame),
    .pixel_valid(pixel_valid), .pixel_input(pixel_input), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .busy(busy),
    .frame_done(frame_done), .sync_error(sync_error)
  );

  frame_capture_streamer #(
    .WIDTH(4), .HEIGHT(2), .CHANNELS(3), .CH_BITS(10), .OUT_BITS(8), .SEL_MSB(1)
  ) u_dut_msb (
    .clk(clk), .reset(reset), .arm(arm), .start_frame(start_frame),
    .pixel_valid(pixel_valid), .pixel_input(pixel_input), .out_ready(out_ready),
    .out_data(out_data_m), .out_valid(out_valid_m), .busy(busy_m),
    .frame_done(frame_done_m), .sync_error(sync_error_m)
  );

  // Monitor: handshake stability, scoreboard pops and pulse counting.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          tests++;
          if (out_valid !== 1'b1 || out_data !== hold_data) begin
            fails++;
            $display("FAIL hold_stable: valid=%0b data=%0h, required valid=1 data=%0h",
                     out_valid, out_data, hold_data);
          end
        end
        hold_pend = out_valid && !out_ready;
        hold_data = out_data;
        if (out_valid && out_ready) begin
          words_seen++;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL word_lsb: got %0h, required no word", out_data);
          end else begin
            e = exp_q.pop_front();
            if (out_data !== e) begin
              fails++;
              $display("FAIL word_lsb: got %0h, required %0h", out_data, e);
            end
          end
        end
        if (out_valid_m && out_ready) begin
          tests++;
          if (exp_m_q.size() == 0) begin
            fails++;
            $display("FAIL word_msb: got %0h, required no word", out_data_m);
          end else begin
            e = exp_m_q.pop_front();
            if (out_data_m !== e) begin
              fails++;
              $display("FAIL word_msb: got %0h, required %0h", out_data_m, e);
            end
          end
        end
        if (frame_done) fd_cnt++;
        if (sync_error) se_cnt++;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill_random;
    for (int p = 0; p < NPIX; p++) frm[p] = PW'({$urandom, $urandom});
  endtask

  task automatic push_expected;
    logic [CB-1:0] c;
    for (int p = 0; p < NPIX; p++) begin
      for (int k = 0; k < CH; k++) begin
        c = frm[p][k*CB +: CB];
        exp_q.push_back(c[7:0]);
        exp_m_q.push_back(c[9:2]);
      end
    end
  endtask

  task automatic arm_pulse;
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  // Junk pixel on the start cycle must be ignored.
  task automatic start_pulse;
    start_frame = 1'b1;
    pixel_valid = 1'b1;
    pixel_input = PW'({$urandom, $urandom});
    @(posedge clk); #1;
    start_frame = 1'b0;
    pixel_valid = 1'b0;
  endtask

  task automatic send_pixels(input bit gaps, input int n);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          pixel_valid = 1'b0;
          pixel_input = PW'({$urandom, $urandom});
          @(posedge clk); #1;
        end
      end
      pixel_valid = 1'b1;
      pixel_input = frm[i];
      @(posedge clk); #1;
    end
    pixel_valid = 1'b0;
  endtask

  task automatic wait_done(input bit rand_ready, input int budget);
    int start = fd_cnt;
    for (int c = 0; c < budget && fd_cnt == start; c++) begin
      if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    tests++;
    if (fd_cnt == start) begin
      fails++;
      $display("FAIL frame_done_timeout: no frame_done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; arm = 1'b0; start_frame = 1'b0; pixel_valid = 1'b0;
    pixel_input = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++;
      $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
    tests++; if (out_data !== 8'h00) begin fails++;
      $display("FAIL reset_out_data: got %0h, required 0", out_data); end
    tests++; if (busy !== 1'b0) begin fails++;
      $display("FAIL reset_busy: got %0b, required 0", busy); end
    tests++; if (frame_done !== 1'b0) begin fails++;
      $display("FAIL reset_frame_done: got %0b, required 0", frame_done); end
    tests++; if (sync_error !== 1'b0) begin fails++;
      $display("FAIL reset_sync_error: got %0b, required 0", sync_error); end
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_basic;
    int lat, bad, w0, f0;
    for (int p = 0; p < NPIX; p++)
      for (int k = 0; k < CH; k++) frm[p][k*CB +: CB] = 10'(16 * p + k + 'h100);
    out_ready = 1'b1;
    w0 = words_seen; f0 = fd_cnt;
    arm_pulse();
    tests++; if (busy !== 1'b1) begin fails++;
      $display("FAIL busy_rise: got %0b, required 1", busy); end
    start_pulse();
    send_pixels(1'b0, NPIX);
    push_expected();
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 10) begin
      lat++;
      @(negedge clk);
    end
    tests++; if (lat != 2) begin fails++;
      $display("FAIL first_word_latency: got %0d, required 2", lat); end
    bad = 0;
    for (int cyc = 1; cyc < NPIX * (CH + 1) - 1; cyc++) begin
      @(negedge clk);
      if (out_valid !== ((cyc % 4) != 3)) bad++;
    end
    tests++; if (bad != 0) begin fails++;
      $display("FAIL bubble_pattern: got %0d wrong cycles, required 0", bad); end
    @(negedge clk);
    tests++; if ({frame_done, busy} !== 2'b10) begin fails++;
      $display("FAIL done_cycle: got done,busy=%0b%0b, required 10", frame_done, busy); end
    @(negedge clk);
    tests++; if (frame_done !== 1'b0) begin fails++;
      $display("FAIL done_width: got %0b, required 0", frame_done); end
    #1;
    tests++; if (words_seen - w0 != NW) begin fails++;
      $display("FAIL basic_word_count: got %0d, required %0d", words_seen - w0, NW); end
    tests++; if (fd_cnt - f0 != 1) begin fails++;
      $display("FAIL basic_done_count: got %0d, required 1", fd_cnt - f0); end
    tests++; if (exp_q.size() != 0) begin fails++;
      $display("FAIL basic_leftover: got %0d, required 0", exp_q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_sel_msb;
    logic [7:0] want [3];
    int n;
    want[0] = 8'hFF; want[1] = 8'h00; want[2] = 8'hAA;
    fill_random();
    frm[0] = {10'h2A8, 10'h003, 10'h3FC};
    out_ready = 1'b1;
    arm_pulse();
    start_pulse();
    send_pixels(1'b0, NPIX);
    push_expected();
    n = 0;
    @(negedge clk);
    while (!out_valid_m && n < 10) begin
      n++;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      tests++;
      if (out_valid_m !== 1'b1 || out_data_m !== want[k]) begin
        fails++;
        $display("FAIL msb_word%0d: got valid=%0b data=%0h, required valid=1 data=%0h",
                 k, out_valid_m, out_data_m, want[k]);
      end
    end
    @(posedge clk); #1;
    wait_done(1'b0, 100);
    tests++; if (exp_m_q.size() != 0) begin fails++;
      $display("FAIL msb_leftover: got %0d, required 0", exp_m_q.size()); end
  endtask

  task automatic test_backpressure;
    int w0 = words_seen;
    fill_random();
    arm_pulse();
    start_pulse();
    send_pixels(1'b1, NPIX);
    push_expected();
    wait_done(1'b1, 2000);
    tests++; if (words_seen - w0 != NW) begin fails++;
      $display("FAIL bp_word_count: got %0d, required %0d", words_seen - w0, NW); end
    tests++; if (exp_q.size() != 0) begin fails++;
      $display("FAIL bp_leftover: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_resync;
    int s0 = se_cnt;
    int w0 = words_seen;
    fill_random();
    out_ready = 1'b1;
    arm_pulse();
    start_pulse();
    send_pixels(1'b0, 5);
    start_pulse();
    @(negedge clk);
    tests++; if (sync_error !== 1'b1) begin fails++;
      $display("FAIL sync_error_pulse: got %0b, required 1", sync_error); end
    @(negedge clk);
    tests++; if (sync_error !== 1'b0) begin fails++;
      $display("FAIL sync_error_width: got %0b, required 0", sync_error); end
    @(posedge clk); #1;
    fill_random();
    send_pixels(1'b1, NPIX);
    push_expected();
    wait_done(1'b0, 200);
    #1;
    tests++; if (se_cnt - s0 != 1) begin fails++;
      $display("FAIL resync_count: got %0d, required 1", se_cnt - s0); end
    tests++; if (words_seen - w0 != NW) begin fails++;
      $display("FAIL resync_word_count: got %0d, required %0d", words_seen - w0, NW); end
  endtask

  task automatic test_ignored;
    int s0 = se_cnt;
    int f0 = fd_cnt;
    int w0 = words_seen;
    bit ended = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      start_frame = 1'b1;
      pixel_valid = 1'b1;
      pixel_input = PW'({$urandom, $urandom});
      @(posedge clk); #1;
    end
    start_frame = 1'b0;
    pixel_valid = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++;
      $display("FAIL idle_ignore_busy: got %0b, required 0", busy); end
    fill_random();
    arm_pulse();
    arm_pulse();
    start_pulse();
    arm = 1'b1;
    send_pixels(1'b0, NPIX);
    arm = 1'b0;
    push_expected();
    for (int c = 0; c < 200 && !ended; c++) begin
      arm = 1'($urandom_range(0, 1));
      start_frame = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!busy) begin
        ended = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    arm = 1'b0;
    start_frame = 1'b0;
    @(posedge clk); #1;
    tests++; if (!ended) begin fails++;
      $display("FAIL ignore_timeout: got busy=1 after 200 cycles, required busy=0"); end
    tests++; if (busy !== 1'b0) begin fails++;
      $display("FAIL ignore_rearm: got busy=%0b, required 0", busy); end
    tests++; if (se_cnt != s0) begin fails++;
      $display("FAIL ignore_sync_error: got %0d pulses, required 0", se_cnt - s0); end
    tests++; if (fd_cnt - f0 != 1) begin fails++;
      $display("FAIL ignore_done_count: got %0d, required 1", fd_cnt - f0); end
    tests++; if (words_seen - w0 != NW) begin fails++;
      $display("FAIL ignore_word_count: got %0d, required %0d", words_seen - w0, NW); end
  endtask

  task automatic test_reset_mid_stream;
    int w0, f0;
    int c = 0;
    fill_random();
    out_ready = 1'b1;
    arm_pulse();
    start_pulse();
    send_pixels(1'b0, NPIX);
    push_expected();
    w0 = words_seen; f0 = fd_cnt;
    while (words_seen - w0 < 10 && c < 200) begin
      @(negedge clk); #1;
      c++;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests++; if ({out_valid, busy} !== 2'b00) begin fails++;
      $display("FAIL mid_reset_idle: got valid,busy=%0b%0b, required 00", out_valid, busy); end
    exp_q.delete();
    exp_m_q.delete();
    repeat (5) @(posedge clk);
    #1;
    tests++; if (fd_cnt != f0) begin fails++;
      $display("FAIL mid_reset_no_done: got %0d pulses, required 0", fd_cnt - f0); end
    w0 = words_seen;
    fill_random();
    arm_pulse();
    start_pulse();
    send_pixels(1'b0, NPIX);
    push_expected();
    wait_done(1'b0, 200);
    #1;
    tests++; if (words_seen - w0 != NW) begin fails++;
      $display("FAIL post_reset_word_count: got %0d, required %0d", words_seen - w0, NW); end
    tests++; if (exp_q.size() != 0) begin fails++;
      $display("FAIL post_reset_leftover: got %0d, required 0", exp_q.size()); end
  endtask

  initial begin : main
    test_reset();
    test_basic();
    test_sel_msb();
    test_backpressure();
    test_resync();
    test_ignored();
    test_reset_mid_stream();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
